// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path (state, opcodes, mux selects).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a; consumers add their own mem_ready handshake.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // State-only part of the control word; handshake-gated enables are added in the top.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       mem_req;
        logic       reg_write;
        logic       retire;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_LUI, S_JALR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNC;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.retire     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t decode_next(input logic [6:0] op);
        state_t s;
        case (op)
            OP_LOAD, OP_STORE: s = S_MEMADR;
            OP_R:              s = S_EXEC_R;
            OP_I:              s = S_EXEC_I;
            OP_BRANCH:         s = S_BRANCH;
            OP_JAL:            s = S_JAL;
            OP_JALR:           s = S_JALR;
            OP_LUI:            s = S_LUI;
            default:           s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/branch_resolver.sv
// Maps func3/zero to a branch-taken flag for beq/bne; other func3 values are not taken.
// Latency: combinational.
// Backpressure: none.
module branch_resolver
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] func3_i,
    input  logic       zero_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (func3_i)
            F3_BEQ:  taken_o = zero_i;
            F3_BNE:  taken_o = !zero_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction plus memory wait cycles.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready_i; optional timeout traps.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TIMEOUT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_i,
    input  logic [2:0] func3_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       MemReq_o,
    output logic       IRWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic       RegWrite_o,
    output logic       retire_o,
    output logic       trap_o
);

    // The trap decision is taken in the wait cycle that would bring the count to MEM_TIMEOUT.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST =
        TIMEOUT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t               state_q, state_d;
    ctrl_t                ctrl_q;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 trap_q, trap_d;
    logic                 taken;
    logic                 in_mem;
    logic                 timed_out;

    branch_resolver u_branch_resolver (
        .func3_i (func3_i),
        .zero_i  (zero_i),
        .taken_o (taken)
    );

    assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timed_out = TIMEOUT_EN && in_mem && !mem_ready_i && (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(op_i);
            S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH:  state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI:   state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (timed_out) state_d = S_TRAP;
    end

    always_comb begin
        wait_d = '0;
        if (TIMEOUT_EN && in_mem && !mem_ready_i && (state_d == state_q))
            wait_d = wait_q + TIMEOUT_W'(1);
    end

    assign trap_d = trap_q || (state_d == S_TRAP);

    // Select/enable word for the next state is registered alongside the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= moore_ctrl(S_FETCH);
            wait_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
            wait_q  <= wait_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        PCWrite_o   = 1'b0;
        AdrSrc_o    = 1'b0;
        MemWrite_o  = 1'b0;
        MemReq_o    = 1'b0;
        IRWrite_o   = 1'b0;
        ResultSrc_o = 2'b00;
        ALUSrcA_o   = 2'b00;
        ALUSrcB_o   = 2'b00;
        ALUOp_o     = 2'b00;
        RegWrite_o  = 1'b0;
        retire_o    = 1'b0;
        if (!rst) begin
            AdrSrc_o    = ctrl_q.adr_src;
            MemWrite_o  = ctrl_q.mem_write;
            MemReq_o    = ctrl_q.mem_req;
            ResultSrc_o = ctrl_q.result_src;
            ALUSrcA_o   = ctrl_q.alu_src_a;
            ALUSrcB_o   = ctrl_q.alu_src_b;
            ALUOp_o     = ctrl_q.alu_op;
            RegWrite_o  = ctrl_q.reg_write;
            IRWrite_o   = (state_q == S_FETCH) && mem_ready_i;
            PCWrite_o   = ctrl_q.pc_write
                       || ((state_q == S_FETCH) && mem_ready_i)
                       || ((state_q == S_BRANCH) && taken);
            retire_o    = ctrl_q.retire || ((state_q == S_MEMWRITE) && mem_ready_i);
        end
    end

    assign trap_o = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a retire scoreboard and a timeout instance.
// Latency: n/a. Backpressure: mem_ready_i is withheld for programmed wait counts.
module tb_multicycle_controller;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_t;
    logic [6:0] op;
    logic [2:0] f3;
    logic       zero, rdy, rdy_t;

    logic       pcw, adr, memw, memreq, irw, regw, ret, trap;
    logic [1:0] rsrc, srca, srcb, aluop;
    logic       pcw_t, adr_t, memw_t, memreq_t, irw_t, regw_t, ret_t, trap_t;
    logic [1:0] rsrc_t, srca_t, srcb_t, aluop_t;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op_i(op), .func3_i(f3), .zero_i(zero), .mem_ready_i(rdy),
        .PCWrite_o(pcw), .AdrSrc_o(adr), .MemWrite_o(memw), .MemReq_o(memreq),
        .IRWrite_o(irw), .ResultSrc_o(rsrc), .ALUSrcA_o(srca), .ALUSrcB_o(srcb),
        .ALUOp_o(aluop), .RegWrite_o(regw), .retire_o(ret), .trap_o(trap)
    );

    multicycle_controller #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut_t (
        .clk(clk), .rst(rst_t), .op_i(op), .func3_i(f3), .zero_i(zero), .mem_ready_i(rdy_t),
        .PCWrite_o(pcw_t), .AdrSrc_o(adr_t), .MemWrite_o(memw_t), .MemReq_o(memreq_t),
        .IRWrite_o(irw_t), .ResultSrc_o(rsrc_t), .ALUSrcA_o(srca_t), .ALUSrcB_o(srcb_t),
        .ALUOp_o(aluop_t), .RegWrite_o(regw_t), .retire_o(ret_t), .trap_o(trap_t)
    );

    typedef struct packed {
        logic       pcw, adr, memw, memreq, irw;
        logic [1:0] rsrc, srca, srcb, aluop;
        logic       regw, ret, trap;
    } obs_t;

    typedef struct {
        int   cycles;
        logic regw;
    } exp_t;

    exp_t sb[$];
    obs_t tr[0:63];
    int   npass = 0;
    int   ntot  = 0;

    function automatic obs_t sample();
        obs_t s;
        s.pcw = pcw; s.adr = adr; s.memw = memw; s.memreq = memreq; s.irw = irw;
        s.rsrc = rsrc; s.srca = srca; s.srcb = srcb; s.aluop = aluop;
        s.regw = regw; s.ret = ret; s.trap = trap;
        return s;
    endfunction

    function automatic logic [5:0] enables(input obs_t s);
        return {s.pcw, s.memw, s.memreq, s.irw, s.regw, s.ret};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Entry and exit at posedge+1. Ready is decided once Moore outputs settle, sampled at +3.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f,
                             input logic z, input int fw, input int dw,
                             input int exp_cyc, input logic exp_rw);
        exp_t e, x;
        int   cyc, waits;
        logic fetched, done;
        e.cycles = exp_cyc;
        e.regw   = exp_rw;
        sb.push_back(e);
        op = o; f3 = f; zero = z;
        cyc = 0; waits = 0; fetched = 1'b0; done = 1'b0;
        while (!done && cyc < 40) begin
            #1;
            if (memreq) begin
                if (waits < (fetched ? dw : fw)) begin
                    rdy = 1'b0;
                    waits++;
                end else begin
                    rdy = 1'b1;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            #1;
            tr[cyc] = sample();
            if (tr[cyc].irw) begin
                fetched = 1'b1;
                waits   = 0;
            end
            if (tr[cyc].ret) begin
                x = sb.pop_front();
                chk({tag, "/cycles"}, cyc + 1, x.cycles);
                chk({tag, "/regwrite_at_retire"}, 32'(tr[cyc].regw), 32'(x.regw));
                done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            x = sb.pop_front();
            chk({tag, "/retire_within_budget"}, 0, 1);
        end
    endtask

    initial begin
        int   hold, rw;
        obs_t exp_fetch;

        rst = 1'b1; rst_t = 1'b1; rdy = 1'b1; rdy_t = 1'b0;
        op = OP_R; f3 = 3'b000; zero = 1'b0;

        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("reset_outputs_zero", sample(), 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;

        run_instr("add", OP_R, 3'b000, 1'b0, 0, 0, 4, 1'b1);
        chk("first_fetch_irwrite", tr[0].irw, 1);
        chk("first_fetch_pcwrite", tr[0].pcw, 1);
        chk("first_fetch_srcb", tr[0].srcb, SRCB_FOUR);
        chk("add_exec_aluop", tr[2].aluop, ALUOP_FUNC);
        chk("add_exec_srcb", tr[2].srcb, SRCB_RS2);
        chk("add_exec_srca", tr[2].srca, SRCA_RS1);

        run_instr("lw", OP_LOAD, 3'b010, 1'b0, 0, 3, 8, 1'b1);
        hold = 0; rw = 0;
        for (int c = 3; c <= 6; c++) hold += int'(tr[c].memreq && tr[c].adr);
        for (int c = 0; c <= 7; c++) rw += int'(tr[c].regw);
        chk("lw_memreq_adrsrc_held", hold, 4);
        chk("lw_regwrite_cycles", rw, 1);
        chk("lw_wb_resultsrc", tr[7].rsrc, RES_DATA);

        run_instr("sw", OP_STORE, 3'b010, 1'b0, 2, 0, 6, 1'b0);
        chk("sw_memwrite", tr[5].memw, 1);
        chk("sw_adrsrc", tr[5].adr, 1);

        run_instr("addi", OP_I, 3'b000, 1'b0, 0, 0, 4, 1'b1);
        chk("addi_exec_srcb", tr[2].srcb, SRCB_IMM);
        run_instr("lui", OP_LUI, 3'b000, 1'b0, 1, 0, 5, 1'b1);

        run_instr("bne_z0", OP_BRANCH, 3'b001, 1'b0, 0, 0, 3, 1'b0);
        chk("bne_z0_pcwrite", tr[2].pcw, 1);
        chk("bne_aluop", tr[2].aluop, ALUOP_SUB);
        run_instr("bne_z1", OP_BRANCH, 3'b001, 1'b1, 0, 0, 3, 1'b0);
        chk("bne_z1_pcwrite", tr[2].pcw, 0);
        run_instr("beq_z1", OP_BRANCH, 3'b000, 1'b1, 0, 0, 3, 1'b0);
        chk("beq_z1_pcwrite", tr[2].pcw, 1);
        run_instr("blt_f3_100", OP_BRANCH, 3'b100, 1'b1, 0, 0, 3, 1'b0);
        chk("f3_100_pcwrite", tr[2].pcw, 0);
        chk("f3_100_no_trap", tr[2].trap, 0);

        run_instr("jal", OP_JAL, 3'b000, 1'b0, 0, 0, 4, 1'b1);
        chk("jal_pcwrite", tr[2].pcw, 1);
        chk("jal_srca", tr[2].srca, SRCA_OLDPC);
        run_instr("jalr", OP_JALR, 3'b000, 1'b0, 0, 0, 5, 1'b1);
        chk("jalr_no_early_pcwrite", tr[2].pcw, 0);
        chk("jalr_pcwrite_in_jal", tr[3].pcw, 1);
        chk("scoreboard_drained", sb.size(), 0);

        op = 7'b1111111;
        for (int c = 0; c < 6; c++) begin
            #1;
            rdy = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            tr[c] = sample();
            @(posedge clk); #1;
        end
        chk("illegal_trap_flag", tr[2].trap, 1);
        chk("illegal_trap_enables", enables(tr[2]), 0);
        chk("trap_sticky", tr[5].trap, 1);
        chk("trap_sticky_enables", enables(tr[5]), 0);
        rst = 1'b1; rdy = 1'b1;
        #2;
        chk("trap_reset_enables", enables(sample()), 0);
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b0; op = OP_R;
        #2;
        exp_fetch        = '0;
        exp_fetch.memreq = 1'b1;
        exp_fetch.srcb   = SRCB_FOUR;
        exp_fetch.rsrc   = RES_ALURESULT;
        chk("post_trap_fetch", sample(), exp_fetch);

        rst_t = 1'b1;
        @(posedge clk); #1;
        rst_t = 1'b0; rdy_t = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            #2;
            chk("timeout_wait_in_fetch", {memreq_t, trap_t}, 2'b10);
            @(posedge clk); #1;
        end
        #2;
        chk("timeout_trap", trap_t, 1);
        chk("timeout_trap_memreq", memreq_t, 0);
        @(posedge clk); #1;

        rst_t = 1'b1;
        @(posedge clk); #1;
        rst_t = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            rdy_t = (w == 4);
            #2;
            if (w == 4) chk("timeout_ready_wins_irwrite", irw_t, 1);
            @(posedge clk); #1;
        end
        rdy_t = 1'b0;
        #2;
        chk("timeout_ready_wins_no_trap", trap_t, 0);
        chk("timeout_ready_wins_decode", {srca_t, srcb_t}, {SRCA_OLDPC, SRCB_IMM});

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
